instruction_fetch: RTL
======================

# instruction_fetch

Pipeline IF stage of the 64-bit LEGv8-style CPU, directly upstream of the decode stage. Owns the program counter and a word-addressed instruction memory, fetches one 32-bit instruction per cycle, and presents the 96-bit IF/ID buffer `{PC, instruction}` that decode latches. Accepts branch redirects (`PCSrc` / `BranchAddress`) resolved downstream, supports a hold (stall) input, and halts on an out-of-range or misaligned PC.

## Interface
- `IMEM_WORDS`, 256: instruction memory depth in 32-bit words, power of two; `AW = log2(IMEM_WORDS)`.
- `RESET_PC`, 64'h0: PC value loaded on reset.
- `NOP_INSTR`, 32'hD503201F: bubble encoding inserted on flush/stall-free idle.
- `clk`  in  1  single clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `PCSrc`  in  1  branch taken; redirect fetch to `BranchAddress`.
- `BranchAddress`  in  64  redirect target.
- `stall`  in  1  hold PC and `outBuf` unchanged.
- `prog_we`  in  1  instruction memory write enable.
- `prog_addr`  in  AW  word address for write.
- `prog_data`  in  32  word to write.
- `outBuf`  out  96  IF/ID buffer: [95:32] PC of instruction, [31:0] instruction.
- `outValid`  out  1  `outBuf` holds a real instruction (0 = bubble).
- `pc`  out  64  current fetch PC.
- `fault`  out  1  sticky: fetch halted on bad PC.

## Operation
- FSM states: BOOT, RUN, HALT. Reset enters BOOT.
- Fetch read is combinational: `imem[pc[AW+1:2]]`; registered into `outBuf` at posedge.
- PC is "bad" when `pc[1:0] != 0` or `pc[63:AW+2] != 0`.
- Per-edge priority: `rst` > `PCSrc` > `stall` > normal.
- `rst`: `pc <= RESET_PC`, `outBuf <= {RESET_PC, NOP_INSTR}`, `outValid <= 0`, `fault <= 0`, state BOOT. Memory contents are not cleared.
- BOOT: emit one bubble (`outValid` 0), PC held; go to RUN.
- RUN, normal: if PC good, `outBuf <= {pc, imem[...]}`, `outValid <= 1`, `pc <= pc + 4` (64-bit, wraps modulo 2^64). If PC bad, `outBuf <= {pc, NOP_INSTR}`, `outValid <= 0`, `fault <= 1`, state HALT, PC held.
- `PCSrc` (any state): `pc <= BranchAddress`, `outBuf <= {pc, NOP_INSTR}`, `outValid <= 0` (flush wrong-path fetch), `fault <= 0`, state RUN. Overrides `stall`.
- `stall` (RUN/BOOT): `pc`, `outBuf`, `outValid`, state unchanged.
- HALT: emit bubbles, PC held; leaves only on `rst` or `PCSrc`.
- `prog_we`: `imem[prog_addr] <= prog_data` at posedge, independent of state and `rst`. Same-cycle fetch of the written address returns old word (read-before-write).

## Timing
- Reset values: `pc = RESET_PC`, `outBuf = {RESET_PC, NOP_INSTR}`, `outValid = 0`, `fault = 0`.
- First valid instruction appears in `outBuf` 2 edges after `rst` deasserts (BOOT bubble, then fetch).
- Fetch latency 1 cycle: instruction at `pc` in cycle N is in `outBuf` after edge N.
- Redirect penalty: 1 bubble; target instruction valid in `outBuf` on the second edge after `PCSrc` sampled high.
- `PCSrc` sampled at posedge only; held-high for k cycles yields k redirects to the then-current `BranchAddress`.
- Reset mid-stall or mid-HALT: reset wins, same reset values.

## Structure
- Shared package: `NOP_INSTR`, IF/ID buffer field offsets (PC [95:32], instr [31:0]), FSM state enum (2 bits), PC increment constant 4. Decode stage imports the same offsets.
- One sub-module natural: `imem_rom` (array, async read, sync write port); PC/FSM/buffer logic stays in top.

## Test plan
- Reset: load words 0–3 = 0x8B020020, 0xF8400041, 0xCB030064, 0xB4000040; deassert `rst` -> one bubble, then `outBuf` = {0, 0x8B020020}, {4, 0xF8400041}, {8, …}, {12, …}, `outValid` 1.
- Stall: assert `stall` 3 cycles at PC=8 -> `outBuf` frozen at {4, 0xF8400041}, `pc` stays 8; release -> {8, 0xCB030064}.
- Redirect: `PCSrc`=1, `BranchAddress`=0x40 at PC=12 -> next `outBuf` = {12, NOP}, `outValid` 0; following = {0x40, imem[16]}, valid 1. Repeat with `stall`=1 simultaneously -> identical result.
- Halt: run to PC = 4*IMEM_WORDS -> `fault` 1, bubbles, `pc` held; `PCSrc` to 0 -> `fault` 0, fetch resumes at 0. Misaligned `BranchAddress`=0x42 -> immediate HALT, `fault` 1.
- Program port: write 0x12345678 to addr 5 in the cycle PC=20 -> that fetch returns old word; refetch after branch to 20 returns 0x12345678.
- Reset mid-HALT and mid-stall -> all outputs return to reset values next edge.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the IF stage and its consumers.
// Holds the bubble encoding, the IF/ID buffer layout, the fetch FSM state
// encoding and the sequential PC step. Decode imports the same field offsets
// so the two stages cannot disagree on the buffer layout.
package instruction_fetch_pkg;

    localparam logic [31:0] IF_NOP_INSTR = 32'hD503201F;

    // IF/ID buffer: {PC, instruction}
    localparam int IFID_W         = 96;
    localparam int IFID_PC_MSB    = 95;
    localparam int IFID_PC_LSB    = 32;
    localparam int IFID_INSTR_MSB = 31;
    localparam int IFID_INSTR_LSB = 0;

    localparam logic [63:0] PC_INCR = 64'd4;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } if_state_e;

    function automatic logic [IFID_W-1:0] pack_ifid(input logic [63:0] pc,
                                                    input logic [31:0] instr);
        return {pc, instr};
    endfunction

endpackage

// File: rtl/instruction_fetch_imem_rom.sv
// Word-addressed instruction memory for the IF stage.
// Ports:
//   clk            - write clock
//   we/waddr/wdata - synchronous program/write port
//   raddr/rdata    - asynchronous read port (fetch)
// A write and a read of the same word in one cycle return the old word,
// since the array only updates at the clock edge.
module imem_rom #(
    parameter int WORDS = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instruction_fetch.sv
// Pipeline IF stage: owns the PC, fetches one 32-bit word per cycle from the
// instruction memory and presents the {PC, instruction} IF/ID buffer.
// Ports:
//   clk, rst                    - clock, synchronous active-high reset
//   PCSrc, BranchAddress        - downstream-resolved redirect
//   stall                       - hold PC and buffer
//   prog_we/prog_addr/prog_data - instruction memory write port
//   outBuf, outValid            - IF/ID buffer and its valid flag
//   pc                          - current fetch PC
//   fault                       - sticky bad-PC halt indicator
//
// state | meaning
// BOOT  | one bubble after reset, PC held
// RUN   | fetching, PC advances by 4 per unstalled cycle
// HALT  | PC out of range or misaligned; bubbles until rst or PCSrc
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int          IMEM_WORDS = 256,
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter logic [31:0] NOP_INSTR  = IF_NOP_INSTR,
    localparam int         AW         = $clog2(IMEM_WORDS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          PCSrc,
    input  logic [63:0]   BranchAddress,
    input  logic          stall,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [31:0]   prog_data,
    output logic [95:0]   outBuf,
    output logic          outValid,
    output logic [63:0]   pc,
    output logic          fault
);

    if_state_e          state_q, state_d;
    logic [63:0]        pc_q, pc_d;
    logic [IFID_W-1:0]  buf_q, buf_d;
    logic               valid_q, valid_d;
    logic               fault_q, fault_d;
    logic [31:0]        fetch_word;
    logic               pc_bad;

    imem_rom #(
        .WORDS (IMEM_WORDS),
        .AW    (AW)
    ) u_imem (
        .clk   (clk),
        .we    (prog_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (pc_q[AW+1:2]),
        .rdata (fetch_word)
    );

    // Any bit above the memory window or a non-word-aligned PC halts fetch.
    assign pc_bad = (pc_q[1:0] != 2'b00) || ((pc_q >> (AW + 2)) != 64'd0);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        buf_d   = buf_q;
        valid_d = valid_q;
        fault_d = fault_q;

        if (PCSrc) begin
            // Flush the wrong-path fetch; the buffer carries the old PC.
            pc_d    = BranchAddress;
            buf_d   = pack_ifid(pc_q, NOP_INSTR);
            valid_d = 1'b0;
            fault_d = 1'b0;
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_BOOT: begin
                    if (!stall) begin
                        buf_d   = pack_ifid(pc_q, NOP_INSTR);
                        valid_d = 1'b0;
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!stall) begin
                        if (pc_bad) begin
                            buf_d   = pack_ifid(pc_q, NOP_INSTR);
                            valid_d = 1'b0;
                            fault_d = 1'b1;
                            state_d = ST_HALT;
                        end else begin
                            buf_d   = pack_ifid(pc_q, fetch_word);
                            valid_d = 1'b1;
                            pc_d    = pc_q + PC_INCR;
                        end
                    end
                end
                ST_HALT: begin
                    buf_d   = pack_ifid(pc_q, NOP_INSTR);
                    valid_d = 1'b0;
                end
                default: begin
                    state_d = ST_BOOT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            buf_q   <= pack_ifid(RESET_PC, NOP_INSTR);
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            buf_q   <= buf_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
        end
    end

    assign outBuf   = buf_q;
    assign outValid = valid_q;
    assign pc       = pc_q;
    assign fault    = fault_q;

endmodule
